// File: rtl/immgen_pipe_pkg.sv
// Shared definitions for the immediate generator: word size, format codes,
// and the occupancy state encoding of the output/skid buffer.
package immgen_pipe_pkg;

  localparam int WORDSIZE = 32;
  localparam int FMT_W    = 3;

  typedef logic [FMT_W-1:0] fmt_t;

  localparam fmt_t IMM_R   = 3'd0;
  localparam fmt_t IMM_I   = 3'd1;
  localparam fmt_t IMM_S   = 3'd2;
  localparam fmt_t IMM_B   = 3'd3;
  localparam fmt_t IMM_U   = 3'd4;
  localparam fmt_t IMM_J   = 3'd5;
  localparam fmt_t IMM_Z   = 3'd6;
  localparam fmt_t IMM_ILL = 3'd7;

  // Number of buffered results: output register only, or output plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/immgen_pipe_if.sv
// Handshake bundle between fetch/align (producer), the immediate generator
// and the register-read stage (consumer).
interface immgen_pipe_if
  import immgen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) ();

  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [WORDSIZE-1:0] in_instr;
  fmt_t                in_fmt;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_imm;
  fmt_t                out_fmt;
  logic                out_err;

  // Environment side: drives words in and accepts results.
  modport master (
    output flush, in_valid, in_instr, in_fmt, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_err
  );

  // Generator side.
  modport slave (
    input  flush, in_valid, in_instr, in_fmt, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_err
  );

endinterface

// File: rtl/immgen_pipe_imm_extract.sv
// Combinational immediate extraction for the base RV formats plus CSR zimm.
// The 32-bit immediate is assembled first and then sign-extended to XLEN
// from bit 31 (zimm has bit 31 clear, so it comes out zero-extended).
module imm_extract
  import immgen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [WORDSIZE-1:0] instr,
  input  fmt_t                fmt,
  output logic [XLEN-1:0]     imm,
  output logic                err
);

  logic [WORDSIZE-1:0] asm_imm;

  // Assemble the 32-bit immediate for the selected format.
  always_comb begin
    asm_imm = '0;
    err     = 1'b0;
    case (fmt)
      IMM_I:   asm_imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   asm_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   asm_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   asm_imm = {instr[31:12], 12'b0};
      IMM_J:   asm_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z:   asm_imm = {27'b0, instr[19:15]};
      IMM_ILL: err     = 1'b1;
      default: asm_imm = '0;  // R format carries no immediate
    endcase
  end

  // Widen to XLEN; only the 64-bit build needs replicated sign bits.
  generate
    if (XLEN > WORDSIZE) begin : g_wide
      assign imm = {{(XLEN-WORDSIZE){asm_imm[WORDSIZE-1]}}, asm_imm};
    end else begin : g_narrow
      assign imm = asm_imm;
    end
  endgenerate

endmodule

// File: rtl/immgen_pipe.sv
// Pipelined immediate generator: combinational extraction on the input side,
// then an output register backed by a one-entry skid register so that
// in_ready is a pure register and full throughput is kept under backpressure.
module immgen_pipe
  import immgen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  immgen_pipe_if.slave bus
);

  logic [XLEN-1:0] ext_imm;
  logic            ext_err;

  occ_state_e      state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [XLEN-1:0] out_imm_q;
  fmt_t            out_fmt_q;
  logic            out_err_q;
  logic [XLEN-1:0] skid_imm_q;
  fmt_t            skid_fmt_q;
  logic            skid_err_q;

  logic acc_in;
  logic acc_out;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr (bus.in_instr),
    .fmt   (bus.in_fmt),
    .imm   (ext_imm),
    .err   (ext_err)
  );

  assign acc_in  = bus.in_valid && in_ready_q;
  assign acc_out = out_valid_q && bus.out_ready;

  // Occupancy FSM with registered handshake outputs and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_fmt_q   <= IMM_R;
      out_err_q   <= 1'b0;
      skid_imm_q  <= '0;
      skid_fmt_q  <= IMM_R;
      skid_err_q  <= 1'b0;
    end else if (bus.flush) begin
      // Drop everything held; a same-cycle input word is discarded too.
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc_in) begin
            out_imm_q   <= ext_imm;
            out_fmt_q   <= bus.in_fmt;
            out_err_q   <= ext_err;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc_in && acc_out) begin
            out_imm_q <= ext_imm;
            out_fmt_q <= bus.in_fmt;
            out_err_q <= ext_err;
          end else if (acc_in) begin
            // Consumer stalled: park the new word and stop accepting.
            skid_imm_q <= ext_imm;
            skid_fmt_q <= bus.in_fmt;
            skid_err_q <= ext_err;
            in_ready_q <= 1'b0;
            state_q    <= ST_TWO;
          end else if (acc_out) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (acc_out) begin
            out_imm_q  <= skid_imm_q;
            out_fmt_q  <= skid_fmt_q;
            out_err_q  <= skid_err_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_fmt   = out_fmt_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench for immgen_pipe: one XLEN=32 and one XLEN=64 instance share
// clock and reset; expected values are hand-computed constants.
module tb_immgen_pipe;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  immgen_pipe_if #(.XLEN(32)) b32 ();
  immgen_pipe_if #(.XLEN(64)) b64 ();

  immgen_pipe #(.XLEN(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  immgen_pipe #(.XLEN(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it differs.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // I-format word whose immediate is the given 12-bit value.
  function automatic logic [31:0] itype(input logic [11:0] v);
    return {v, 20'h00093};
  endfunction

  task automatic push32(input string tag, input logic [31:0] instr, input logic [2:0] fmt,
                        input logic [31:0] eimm, input logic eerr);
    b32.in_valid  = 1'b1;
    b32.in_instr  = instr;
    b32.in_fmt    = fmt;
    b32.out_ready = 1'b1;
    chk({tag, ".in_ready"}, b32.in_ready, 1);
    step();
    b32.in_valid = 1'b0;
    chk({tag, ".out_valid"}, b32.out_valid, 1);
    chk({tag, ".imm"}, b32.out_imm, eimm);
    chk({tag, ".fmt"}, b32.out_fmt, fmt);
    chk({tag, ".err"}, b32.out_err, eerr);
    $display("xfer32 %s instr=%h fmt=%0d imm=%h err=%b", tag, instr, fmt, b32.out_imm, b32.out_err);
  endtask

  task automatic push64(input string tag, input logic [31:0] instr, input logic [2:0] fmt,
                        input logic [63:0] eimm, input logic eerr);
    b64.in_valid  = 1'b1;
    b64.in_instr  = instr;
    b64.in_fmt    = fmt;
    b64.out_ready = 1'b1;
    chk({tag, ".in_ready"}, b64.in_ready, 1);
    step();
    b64.in_valid = 1'b0;
    chk({tag, ".out_valid"}, b64.out_valid, 1);
    chk({tag, ".imm"}, b64.out_imm, eimm);
    chk({tag, ".fmt"}, b64.out_fmt, fmt);
    chk({tag, ".err"}, b64.out_err, eerr);
    $display("xfer64 %s instr=%h fmt=%0d imm=%h err=%b", tag, instr, fmt, b64.out_imm, b64.out_err);
  endtask

  initial begin
    b32.flush = 0; b32.in_valid = 0; b32.in_instr = '0; b32.in_fmt = '0; b32.out_ready = 0;
    b64.flush = 0; b64.in_valid = 0; b64.in_instr = '0; b64.in_fmt = '0; b64.out_ready = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #6;
    // Reset state
    chk("rst.in_ready", b32.in_ready, 1);
    chk("rst.out_valid", b32.out_valid, 0);
    chk("rst.imm", b32.out_imm, 0);
    chk("rst.fmt", b32.out_fmt, 0);
    chk("rst.err", b32.out_err, 0);
    chk("rst64.out_valid", b64.out_valid, 0);
    #5 rst_n = 1'b1;

    // XLEN=32 formats with out_ready=1
    push32("fmtI", 32'hFFF00093, 3'd1, 32'hFFFFFFFF, 1'b0);
    push32("fmtS", 32'hFE112C23, 3'd2, 32'hFFFFFFF8, 1'b0);
    push32("fmtB", 32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 1'b0);
    push32("fmtU", 32'h123450B7, 3'd4, 32'h12345000, 1'b0);
    push32("fmtJpos", 32'h0080006F, 3'd5, 32'h00000008, 1'b0);
    push32("fmtJneg", 32'hFFDFF06F, 3'd5, 32'hFFFFFFFC, 1'b0);
    push32("fmtR", 32'hFFFFFFB3, 3'd0, 32'h00000000, 1'b0);
    push32("fmtZ", 32'h0007D073, 3'd6, 32'h0000000F, 1'b0);
    push32("fmtIll", 32'hFFFFFFFF, 3'd7, 32'h00000000, 1'b1);
    step();
    chk("idle.out_valid", b32.out_valid, 0);

    // XLEN=64 extension
    push64("x64U", 32'h800000B7, 3'd4, 64'hFFFFFFFF80000000, 1'b0);
    push64("x64Z", 32'h0007D073, 3'd6, 64'h000000000000000F, 1'b0);
    push64("x64I", 32'hFFF00093, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    push64("x64Ill", 32'hFFFFFFFF, 3'd7, 64'h0, 1'b1);
    step();
    chk("idle64.out_valid", b64.out_valid, 0);

    // Backpressure: 4 words, out_ready low for 3 cycles
    b32.out_ready = 0;
    b32.in_valid = 1; b32.in_fmt = 3'd1; b32.in_instr = itype(12'h011);
    chk("bp.rdy0", b32.in_ready, 1);
    step();
    chk("bp.w0.vld", b32.out_valid, 1);
    chk("bp.w0.imm", b32.out_imm, 32'h011);
    b32.in_instr = itype(12'h022);
    chk("bp.rdy1", b32.in_ready, 1);
    step();
    chk("bp.rdy_fall", b32.in_ready, 0);
    chk("bp.stall1.imm", b32.out_imm, 32'h011);
    b32.in_instr = itype(12'h033);
    step();
    chk("bp.stall2.rdy", b32.in_ready, 0);
    chk("bp.stall2.vld", b32.out_valid, 1);
    chk("bp.stall2.imm", b32.out_imm, 32'h011);
    $display("xfer32 bp stall imm=%h in_ready=%b", b32.out_imm, b32.in_ready);
    b32.out_ready = 1;
    step();
    chk("bp.rel.w1.vld", b32.out_valid, 1);
    chk("bp.rel.w1.imm", b32.out_imm, 32'h022);
    chk("bp.rel.rdy", b32.in_ready, 1);
    step();
    chk("bp.w2.vld", b32.out_valid, 1);
    chk("bp.w2.imm", b32.out_imm, 32'h033);
    b32.in_instr = itype(12'h044);
    step();
    b32.in_valid = 0;
    chk("bp.w3.vld", b32.out_valid, 1);
    chk("bp.w3.imm", b32.out_imm, 32'h044);
    $display("xfer32 bp drained last imm=%h", b32.out_imm);
    step();
    chk("bp.empty", b32.out_valid, 0);

    // Full throughput: 16 back-to-back words
    b32.out_ready = 1; b32.in_fmt = 3'd1;
    for (int i = 0; i < 16; i++) begin
      b32.in_valid = 1;
      b32.in_instr = itype(12'(i * 16 + 3));
      chk($sformatf("tp%0d.rdy", i), b32.in_ready, 1);
      step();
      chk($sformatf("tp%0d.vld", i), b32.out_valid, 1);
      chk($sformatf("tp%0d.imm", i), b32.out_imm, 64'(i * 16 + 3));
      $display("xfer32 tp%0d imm=%h", i, b32.out_imm);
    end
    b32.in_valid = 0;
    step();
    chk("tp.empty", b32.out_valid, 0);

    // Flush in TWO with a same-cycle input word
    b32.out_ready = 0; b32.in_valid = 1; b32.in_fmt = 3'd1;
    b32.in_instr = itype(12'h0A1);
    step();
    b32.in_instr = itype(12'h0A2);
    step();
    chk("fl.two.rdy", b32.in_ready, 0);
    b32.in_instr = itype(12'h0A3);
    b32.flush = 1;
    step();
    b32.flush = 0; b32.in_valid = 0; b32.out_ready = 1;
    chk("fl.vld", b32.out_valid, 0);
    chk("fl.rdy", b32.in_ready, 1);
    $display("xfer32 flush out_valid=%b in_ready=%b", b32.out_valid, b32.in_ready);
    step();
    chk("fl.post1.vld", b32.out_valid, 0);
    step();
    chk("fl.post2.vld", b32.out_valid, 0);
    push32("fl.next", itype(12'h0A4), 3'd1, 32'h0A4, 1'b0);
    step();

    // Asynchronous reset mid-stream in ONE
    b32.out_ready = 0;
    b32.in_valid = 1; b32.in_fmt = 3'd4; b32.in_instr = 32'h800000B7;
    step();
    b32.in_valid = 0;
    chk("mr.one.vld", b32.out_valid, 1);
    chk("mr.one.imm", b32.out_imm, 32'h80000000);
    #2 rst_n = 1'b0;
    #1;
    chk("mr.rdy", b32.in_ready, 1);
    chk("mr.vld", b32.out_valid, 0);
    chk("mr.imm", b32.out_imm, 0);
    chk("mr.fmt", b32.out_fmt, 0);
    chk("mr.err", b32.out_err, 0);
    rst_n = 1'b1;
    push32("mr.next", 32'hFE112C23, 3'd2, 32'hFFFFFFF8, 1'b0);
    step();
    chk("mr.empty", b32.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
